// File: rtl/theta_page_sequencer_if.sv
// Bus between the theta page sequencer and its controller / state page RAM.
//   start   : run request from the permutation controller
//   busy    : run in progress (through the done cycle)
//   done    : one-cycle pulse after the last page write
//   rd_en   : page read strobe; rd_data is returned one cycle later
//   rd_addr : page read address (0 when rd_en is low)
//   rd_data : 25-bit page, bit i = 5*y + x
//   wr_en   : page write strobe
//   wr_addr : page write address (0 when wr_en is low)
//   wr_data : theta-adjusted page
// master = sequencer side, slave = controller/RAM side.
interface theta_page_sequencer_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [0:24]       rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [0:24]       wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/theta_page_sequencer.sv
// Keccak theta step over a sliced state of PAGES 25-bit pages (one z-slice each).
// Primes the previous-page register with page PAGES-1, then for every page z:
// reads it, computes the 25 output bits serially (one per cycle, y outer, x inner),
// and writes the result back to the same address. 28 cycles per page.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, aborts a run immediately
//   bus   : theta_page_sequencer_if master modport (start/busy/done + page RAM)
module theta_page_sequencer #(
  parameter int unsigned PAGES  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input logic                    clk,
  input logic                    rst_n,
  theta_page_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LastPage = ADDR_W'(PAGES - 1);

  typedef enum logic [2:0] {
    StIdle, StPrimeReq, StPrimeCap, StFetchReq, StFetchCap, StCalc, StWrite, StDone
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] z_q;
  logic [2:0]        x_q, y_q;
  logic [0:24]       prev_q, cur_q, out_q;
  logic              busy_q, done_q, rd_en_q, wr_en_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;

  // Column parities of the current and previous page.
  logic [4:0] par_cur, par_prev;
  always_comb begin
    par_cur  = '0;
    par_prev = '0;
    for (int c = 0; c < 5; c++) begin
      par_cur[c]  = cur_q[c] ^ cur_q[c+5] ^ cur_q[c+10] ^ cur_q[c+15] ^ cur_q[c+20];
      par_prev[c] = prev_q[c] ^ prev_q[c+5] ^ prev_q[c+10] ^ prev_q[c+15] ^ prev_q[c+20];
    end
  end

  logic [2:0] x_m1, x_p1;
  logic [4:0] bit_idx;
  logic       calc_bit;
  always_comb begin
    x_m1     = (x_q == 3'd0) ? 3'd4 : x_q - 3'd1;
    x_p1     = (x_q == 3'd4) ? 3'd0 : x_q + 3'd1;
    bit_idx  = ({2'b00, y_q} << 2) + {2'b00, y_q} + {2'b00, x_q};
    calc_bit = cur_q[bit_idx] ^ par_cur[x_m1] ^ par_prev[x_p1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      z_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      out_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      // Strobes are single-cycle; each state that needs one sets it for the next state.
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q   <= StPrimeReq;
            z_q       <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= LastPage;
          end
        end
        StPrimeReq: state_q <= StPrimeCap;
        StPrimeCap: begin
          // Original page PAGES-1 is held here before page 0 is ever written.
          prev_q    <= bus.rd_data;
          state_q   <= StFetchReq;
          rd_en_q   <= 1'b1;
          rd_addr_q <= z_q;
        end
        StFetchReq: state_q <= StFetchCap;
        StFetchCap: begin
          cur_q   <= bus.rd_data;
          x_q     <= '0;
          y_q     <= '0;
          state_q <= StCalc;
        end
        StCalc: begin
          out_q[bit_idx] <= calc_bit;
          if (x_q == 3'd4) begin
            x_q <= '0;
            if (y_q == 3'd4) begin
              state_q   <= StWrite;
              wr_en_q   <= 1'b1;
              wr_addr_q <= z_q;
            end else begin
              y_q <= y_q + 3'd1;
            end
          end else begin
            x_q <= x_q + 3'd1;
          end
        end
        StWrite: begin
          prev_q <= cur_q;
          if (z_q == LastPage) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            z_q       <= z_q + 1'b1;
            state_q   <= StFetchReq;
            rd_en_q   <= 1'b1;
            rd_addr_q <= z_q + 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = out_q;

endmodule

// File: tb/tb_theta_page_sequencer.sv
// Bench for theta_page_sequencer: a 4-page instance driven from a vector table plus
// reset/re-start sequences, and a 64-page instance with random state against a
// page-level theta model.
module tb_theta_page_sequencer;

  typedef logic [0:24] page_t;

  typedef struct packed {
    page_t [3:0] init;
    page_t [3:0] exp;
    logic        rep;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  theta_page_sequencer_if #(.ADDR_W(2)) b4 ();
  theta_page_sequencer_if #(.ADDR_W(6)) b64 ();

  theta_page_sequencer #(.PAGES(4), .ADDR_W(2)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.master)
  );

  theta_page_sequencer #(.PAGES(64), .ADDR_W(6)) u64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b64.master)
  );

  // Page RAMs: synchronous read (one-cycle latency), read returns pre-write data.
  page_t mem4 [4];
  page_t init4 [4];
  logic  ld4 = 1'b0;
  page_t mem64 [64];
  page_t init64 [64];
  logic  ld64 = 1'b0;

  always @(posedge clk) begin
    if (ld4) begin
      for (int k = 0; k < 4; k++) mem4[k] <= init4[k];
    end else begin
      if (b4.rd_en) b4.rd_data <= mem4[b4.rd_addr];
      if (b4.wr_en) mem4[b4.wr_addr] <= b4.wr_data;
    end
  end

  always @(posedge clk) begin
    if (ld64) begin
      for (int k = 0; k < 64; k++) mem64[k] <= init64[k];
    end else begin
      if (b64.rd_en) b64.rd_data <= mem64[b64.rd_addr];
      if (b64.wr_en) mem64[b64.wr_addr] <= b64.wr_data;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  function automatic page_t pg(input logic [24:0] m);
    page_t p;
    for (int i = 0; i < 25; i++) p[i] = m[i];
    return p;
  endfunction

  // Theta on one page given the page and its predecessor slice.
  function automatic page_t theta_page(input page_t cur, input page_t prv);
    logic [4:0] cc, cp;
    page_t o;
    for (int x = 0; x < 5; x++) begin
      cc[x] = 1'b0;
      cp[x] = 1'b0;
      for (int y = 0; y < 5; y++) begin
        cc[x] = cc[x] ^ cur[5*y+x];
        cp[x] = cp[x] ^ prv[5*y+x];
      end
    end
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        o[5*y+x] = cur[5*y+x] ^ cc[(x+4)%5] ^ cp[(x+1)%5];
    return o;
  endfunction

  task automatic load4(input page_t [3:0] v);
    for (int k = 0; k < 4; k++) init4[k] = v[k];
    @(negedge clk) ld4 = 1'b1;
    @(negedge clk) ld4 = 1'b0;
  endtask

  // One full 4-page run starting at the next negedge (cycle 0 = start-accept cycle).
  task automatic run4(input string nm, input page_t [3:0] exp, input bit rep);
    int wc[$];
    int wa[$];
    page_t wd[$];
    int dc[$];
    int bf, bl, bn, viol;
    bf = -1; bl = -1; bn = 0; viol = 0;
    @(negedge clk);
    chk({nm, "_idle_busy"}, longint'(b4.busy), 0);
    b4.start = 1'b1;
    for (int rel = 1; rel <= 130; rel++) begin
      @(negedge clk);
      b4.start = rep && (rel == 10 || rel == 60);
      if (b4.wr_en) begin
        wc.push_back(rel);
        wa.push_back(int'(b4.wr_addr));
        wd.push_back(b4.wr_data);
      end
      if (b4.done) dc.push_back(rel);
      if (b4.busy) begin
        if (bf < 0) bf = rel;
        bl = rel;
        bn++;
      end
      if ((b4.rd_en && b4.wr_en) || (!b4.rd_en && b4.rd_addr != '0) ||
          (!b4.wr_en && b4.wr_addr != '0)) viol++;
    end
    b4.start = 1'b0;
    chk({nm, "_nwrites"}, wc.size(), 4);
    for (int k = 0; k < 4 && k < wc.size(); k++) begin
      chk($sformatf("%s_wcyc%0d", nm, k), wc[k], 30 + 28 * k);
      chk($sformatf("%s_waddr%0d", nm, k), wa[k], k);
      chk($sformatf("%s_wdata%0d", nm, k), longint'(wd[k]), longint'(exp[k]));
      chk($sformatf("%s_mem%0d", nm, k), longint'(mem4[k]), longint'(exp[k]));
    end
    chk({nm, "_ndone"}, dc.size(), 1);
    if (dc.size() > 0) chk({nm, "_done_cyc"}, dc[0], 115);
    chk({nm, "_busy_first"}, bf, 1);
    chk({nm, "_busy_last"}, bl, 115);
    chk({nm, "_busy_cnt"}, bn, 115);
    chk({nm, "_strobe_rules"}, viol, 0);
  endtask

  vec_t vt [5];

  initial begin
    page_t [3:0] snap;
    page_t [3:0] exp;
    b4.start  = 1'b0;
    b64.start = 1'b0;

    // Vector table: {initial pages, expected written pages, re-pulse start}.
    vt[0] = '{init: '0, exp: '0, rep: 1'b0};
    vt[1] = '{init: '0, exp: '0, rep: 1'b0};
    vt[1].init[0] = pg(25'h1);
    vt[1].exp[0]  = pg(25'h210843);
    vt[1].exp[1]  = pg(25'h1084210);
    vt[2] = '{init: '0, exp: '0, rep: 1'b0};
    vt[2].init[3] = pg(25'h4);
    vt[2].exp[0]  = pg(25'h210842);
    vt[2].exp[3]  = pg(25'h84210C);
    vt[3] = vt[1];
    vt[3].rep = 1'b1;
    vt[4] = '{init: '0, exp: '0, rep: 1'b0};
    vt[4].init[1] = pg(25'h1000);
    vt[4].exp[1]  = pg(25'h843108);
    vt[4].exp[2]  = pg(25'h210842);

    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(b4.busy), 0);
    chk("rst_done", longint'(b4.done), 0);
    chk("rst_rd_en", longint'(b4.rd_en), 0);
    chk("rst_wr_en", longint'(b4.wr_en), 0);
    chk("rst_wr_data", longint'(b4.wr_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      load4(vt[i].init);
      run4($sformatf("vec%0d", i), vt[i].exp, vt[i].rep);
    end

    // Reset while page 1 is in CALC.
    load4(vt[1].init);
    @(negedge clk);
    b4.start = 1'b1;
    for (int rel = 1; rel <= 40; rel++) begin
      @(negedge clk);
      b4.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", longint'(b4.busy), 0);
    chk("abort_rd_en", longint'(b4.rd_en), 0);
    chk("abort_wr_en", longint'(b4.wr_en), 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_strobe", longint'(b4.rd_en | b4.wr_en), 0);
    end
    rst_n = 1'b1;
    chk("abort_mem0", longint'(mem4[0]), longint'(vt[1].exp[0]));
    for (int k = 1; k < 4; k++)
      chk($sformatf("abort_mem%0d", k), longint'(mem4[k]), longint'(vt[1].init[k]));
    // Fresh run over whatever is in memory now.
    for (int k = 0; k < 4; k++) snap[k] = mem4[k];
    for (int k = 0; k < 4; k++) exp[k] = theta_page(snap[k], snap[(k + 3) % 4]);
    run4("restart", exp, 1'b0);

    // 64-page random state against the model.
    begin
      page_t ref64 [64];
      int nw, dcyc, nd;
      nw = 0; nd = 0; dcyc = -1;
      for (int k = 0; k < 64; k++) init64[k] = page_t'($urandom);
      for (int k = 0; k < 64; k++) ref64[k] = theta_page(init64[k], init64[(k + 63) % 64]);
      @(negedge clk) ld64 = 1'b1;
      @(negedge clk) ld64 = 1'b0;
      @(negedge clk);
      b64.start = 1'b1;
      for (int rel = 1; rel <= 1850; rel++) begin
        @(negedge clk);
        b64.start = 1'b0;
        if (b64.wr_en) begin
          if (nw < 64) begin
            chk($sformatf("r64_wcyc%0d", nw), rel, 30 + 28 * nw);
            chk($sformatf("r64_waddr%0d", nw), longint'(b64.wr_addr), nw);
            chk($sformatf("r64_wdata%0d", nw), longint'(b64.wr_data), longint'(ref64[nw]));
          end
          nw++;
        end
        if (b64.done) begin
          nd++;
          dcyc = rel;
        end
      end
      chk("r64_nwrites", nw, 64);
      chk("r64_ndone", nd, 1);
      chk("r64_done_cyc", dcyc, 1795);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
